dm_cache_data_arbiter: RTL and testbench
========================================

Name: dm_cache_data_arbiter

Overview:
- Shares the single-port cache data BRAM (1-cycle read latency, write-first) between two requesters: the CPU pipeline (lookup/store hits) and the refill/writeback engine.
- Grants at most one access per cycle and drives the BRAM port.
- Routes read data back to the requester that issued the read.
- Bounds refill starvation with a counter and supports a refill lock for multi-cycle line bursts.

Parameters:
- SET_NUM, 32, number of sets in the data BRAM; index width IW = $clog2(SET_NUM).
- STARVE_LIMIT, 4, consecutive cycles a pending fill request may lose arbitration before it is forced; must be ≥ 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cpu_req_valid  in  1  CPU request valid
- cpu_req_ready  out  1  CPU request accepted this cycle
- cpu_req_we  in  1  1 = write, 0 = read
- cpu_req_index  in  IW  set index
- cpu_req_data  in  $bits(cache_data_type)  write data
- cpu_rsp_valid  out  1  CPU read data valid
- cpu_rsp_data  out  $bits(cache_data_type)  CPU read data
- fill_req_valid, fill_req_ready, fill_req_we, fill_req_index, fill_req_data  same as CPU, for the refill engine
- fill_lock  in  1  refill engine holds exclusive ownership of the port
- fill_rsp_valid  out  1  fill read data valid
- fill_rsp_data  out  $bits(cache_data_type)  fill read data
- bram_ena  out  1  BRAM enable
- bram_wea  out  1  BRAM write enable
- bram_addra  out  IW  BRAM address
- bram_dina  out  $bits(cache_data_type)  BRAM write data
- bram_douta  in  $bits(cache_data_type)  BRAM read data, valid 1 cycle after a read enable

Behaviour:
- Handshake: a request transfers when valid && ready.
  - Ready is combinational from the valids, fill_lock and force; it never depends on the requester's own we/index/data.
  - Requester holds all request fields stable while valid && !ready.
- Grant, evaluated each cycle:
  - force = (starve_cnt == STARVE_LIMIT).
  - fill_lock = 1: fill_req_ready = 1, cpu_req_ready = 0.
  - Otherwise: cpu_req_ready = !(force && fill_req_valid); fill_req_ready = !cpu_req_valid || force.
  - Net effect: CPU has priority unless force is set; the two grants are never both issued.
- BRAM drive:
  - On a grant: bram_ena = 1; bram_wea/addra/dina take the granted requester's we/index/data.
  - With no grant: bram_ena = 0, bram_wea = 0; addra and dina hold their last values.
- Starvation counter starve_cnt, width $clog2(STARVE_LIMIT+1):
  - Cleared when fill_req_valid = 0 or the fill is granted.
  - Incremented when fill_req_valid = 1 and not granted; saturates at STARVE_LIMIT.
  - fill_lock cycles count as fill grants.
- Response routing:
  - rd_owner register, encoded NONE/CPU/FILL, loads the owner of a granted read and NONE otherwise (writes and idle cycles both load NONE).
  - Next cycle: the matching *_rsp_valid = 1 and *_rsp_data = bram_douta.
  - Writes produce no response.
  - Responses cannot be back-pressured; the sink must accept.
  - Back-to-back reads give back-to-back responses, each exactly 1 cycle after its grant.
  - The non-owner's rsp_data is don't-care; drive 0.
- Simultaneous events:
  - fill_lock rising while a CPU read response is in flight: that response is still delivered to the CPU the next cycle.
  - fill_lock with fill_req_valid = 0: port idles and the CPU stays blocked.
- Reset, asserted at any time:
  - starve_cnt = 0, rd_owner = NONE, cpu_rsp_valid = 0, fill_rsp_valid = 0, bram_ena = 0, bram_wea = 0, bram_addra = 0, bram_dina = 0.
  - Any in-flight read response is dropped.
  - The ready outputs remain combinational.

Test Plan:
- Reset, then CPU reads index 5 holding 0xA5…: grant in cycle T; cpu_rsp_valid = 1 and data = 0xA5… at T+1; fill_rsp_valid stays 0.
- CPU and fill both valid every cycle, STARVE_LIMIT = 4: CPU wins 4 cycles, fill is forced on the 5th, starve_cnt returns to 0, and the pattern repeats (4:1).
- fill_lock = 1 for 8 cycles with fill writes to indices 0–7 while the CPU is valid: cpu_req_ready = 0 throughout; 8 BRAM writes with wea = 1 and addra 0–7; no responses.
- Alternating CPU read index 3 and fill read index 9 on consecutive cycles: responses alternate owners, each exactly 1 cycle after its grant, with matching data.
- CPU read granted, rst asserted in the next cycle: no cpu_rsp_valid pulse; all outputs at reset values while rst = 0.
- CPU write then immediate read of the same index 12 with 0x3C…: read response returns 0x3C…, and the write cycle produces no response.

Source files
------------

// File: rtl/dm_cache_data_arbiter.sv
// ---------------------------------------------------------------------------
// dm_cache_data_arbiter
//
// Shares the single-port cache data BRAM (1-cycle read latency, write-first)
// between the CPU pipeline and the refill/writeback engine. At most one access
// is granted per cycle. The CPU has priority, but a fill request that keeps
// losing is forced through after STARVE_LIMIT cycles. fill_lock gives the refill
// engine exclusive use of the port for multi-cycle line bursts. Read data is
// routed back to whichever requester issued the read, one cycle after its grant.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   cpu_req_*                   CPU request channel (valid/ready/we/index/data)
//   cpu_rsp_valid/data          CPU read response (cannot be back-pressured)
//   fill_req_*                  refill engine request channel
//   fill_lock                   refill engine holds exclusive port ownership
//   fill_rsp_valid/data         refill engine read response
//   bram_ena/wea/addra/dina     BRAM port drive
//   bram_douta                  BRAM read data, valid 1 cycle after a read enable
// ---------------------------------------------------------------------------
module dm_cache_data_arbiter #(
    parameter  int SET_NUM      = 32,
    parameter  int STARVE_LIMIT = 4,
    parameter  int DATA_W       = 32,
    localparam int IW           = $clog2(SET_NUM)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [IW-1:0]     cpu_req_index,
    input  logic [DATA_W-1:0] cpu_req_data,
    output logic              cpu_rsp_valid,
    output logic [DATA_W-1:0] cpu_rsp_data,

    input  logic              fill_req_valid,
    output logic              fill_req_ready,
    input  logic              fill_req_we,
    input  logic [IW-1:0]     fill_req_index,
    input  logic [DATA_W-1:0] fill_req_data,
    input  logic              fill_lock,
    output logic              fill_rsp_valid,
    output logic [DATA_W-1:0] fill_rsp_data,

    output logic              bram_ena,
    output logic              bram_wea,
    output logic [IW-1:0]     bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    input  logic [DATA_W-1:0] bram_douta
);

    typedef logic [DATA_W-1:0] cache_data_type;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_FILL = 2'd2
    } owner_e;

    logic [CW-1:0]  starve_cnt_q, starve_cnt_d;
    owner_e         rd_owner_q, rd_owner_d;
    logic [IW-1:0]  addra_q, addra_d;
    cache_data_type dina_q, dina_d;

    logic force_fill;
    logic cpu_grant;
    logic fill_grant;
    logic sel_we;

    // Ready depends only on valids, lock and the starvation force, never on
    // the requester's own we/index/data.
    always_comb begin
        force_fill = (starve_cnt_q == CNT_MAX);
        if (fill_lock) begin
            cpu_req_ready  = 1'b0;
            fill_req_ready = 1'b1;
        end else begin
            cpu_req_ready  = !(force_fill && fill_req_valid);
            fill_req_ready = !cpu_req_valid || force_fill;
        end
    end

    assign cpu_grant  = cpu_req_valid  && cpu_req_ready;
    assign fill_grant = fill_req_valid && fill_req_ready;

    always_comb begin
        sel_we       = 1'b0;
        addra_d      = addra_q;
        dina_d       = dina_q;
        rd_owner_d   = OWN_NONE;
        starve_cnt_d = starve_cnt_q;

        if (fill_grant) begin
            sel_we  = fill_req_we;
            addra_d = fill_req_index;
            dina_d  = fill_req_data;
            if (!fill_req_we) rd_owner_d = OWN_FILL;
        end else if (cpu_grant) begin
            sel_we  = cpu_req_we;
            addra_d = cpu_req_index;
            dina_d  = cpu_req_data;
            if (!cpu_req_we) rd_owner_d = OWN_CPU;
        end

        // Lock cycles with a fill pending are fill grants, so they clear too.
        if (!fill_req_valid || fill_grant) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
            rd_owner_q   <= OWN_NONE;
            addra_q      <= '0;
            dina_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
            addra_q      <= addra_d;
            dina_q       <= dina_d;
        end
    end

    // The BRAM port is driven combinationally so a read granted in cycle T
    // returns data in T+1. Address/data hold their last granted values when
    // idle; the port is forced quiet while reset is asserted because the
    // ready outputs (and thus grants) stay live during reset.
    always_comb begin
        bram_ena   = rst && (cpu_grant || fill_grant);
        bram_wea   = bram_ena && sel_we;
        bram_addra = rst ? addra_d : '0;
        bram_dina  = rst ? dina_d  : '0;
    end

    always_comb begin
        cpu_rsp_valid  = (rd_owner_q == OWN_CPU);
        fill_rsp_valid = (rd_owner_q == OWN_FILL);
        cpu_rsp_data   = cpu_rsp_valid  ? bram_douta : '0;
        fill_rsp_data  = fill_rsp_valid ? bram_douta : '0;
    end

endmodule

// File: tb/tb_dm_cache_data_arbiter.sv
module tb_dm_cache_data_arbiter;

    localparam int SET_NUM = 32;
    localparam int IW      = 5;
    localparam int DATA_W  = 32;

    logic              clk;
    logic              rst;
    logic              cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [IW-1:0]     cpu_req_index;
    logic [DATA_W-1:0] cpu_req_data;
    logic              cpu_rsp_valid;
    logic [DATA_W-1:0] cpu_rsp_data;
    logic              fill_req_valid, fill_req_ready, fill_req_we;
    logic [IW-1:0]     fill_req_index;
    logic [DATA_W-1:0] fill_req_data;
    logic              fill_lock;
    logic              fill_rsp_valid;
    logic [DATA_W-1:0] fill_rsp_data;
    logic              bram_ena, bram_wea;
    logic [IW-1:0]     bram_addra;
    logic [DATA_W-1:0] bram_dina;
    logic [DATA_W-1:0] bram_douta;

    int n_checks;
    int n_errors;

    logic [DATA_W-1:0] mem [SET_NUM];

    dm_cache_data_arbiter #(
        .SET_NUM      (SET_NUM),
        .STARVE_LIMIT (4),
        .DATA_W       (DATA_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_index  (cpu_req_index),
        .cpu_req_data   (cpu_req_data),
        .cpu_rsp_valid  (cpu_rsp_valid),
        .cpu_rsp_data   (cpu_rsp_data),
        .fill_req_valid (fill_req_valid),
        .fill_req_ready (fill_req_ready),
        .fill_req_we    (fill_req_we),
        .fill_req_index (fill_req_index),
        .fill_req_data  (fill_req_data),
        .fill_lock      (fill_lock),
        .fill_rsp_valid (fill_rsp_valid),
        .fill_rsp_data  (fill_rsp_data),
        .bram_ena       (bram_ena),
        .bram_wea       (bram_wea),
        .bram_addra     (bram_addra),
        .bram_dina      (bram_dina),
        .bram_douta     (bram_douta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM model: 1-cycle read latency, write-first.
    always @(posedge clk) begin
        if (bram_ena) begin
            if (bram_wea) begin
                mem[bram_addra] <= bram_dina;
                bram_douta      <= bram_dina;
            end else begin
                bram_douta      <= mem[bram_addra];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req_valid  = 1'b0;
        cpu_req_we     = 1'b0;
        cpu_req_index  = '0;
        cpu_req_data   = '0;
        fill_req_valid = 1'b0;
        fill_req_we    = 1'b0;
        fill_req_index = '0;
        fill_req_data  = '0;
        fill_lock      = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        bram_douta = '0;
        for (int i = 0; i < SET_NUM; i++) mem[i] = 32'h0;
        mem[5] = 32'hA5A5_A5A5;
        mem[9] = 32'h9999_9999;
        idle_inputs();

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_rsp_valid",  cpu_rsp_valid,  1'b0);
        chk("rst_fill_rsp_valid", fill_rsp_valid, 1'b0);
        chk("rst_bram_ena",       bram_ena,       1'b0);
        chk("rst_bram_wea",       bram_wea,       1'b0);
        chk("rst_bram_addra",     bram_addra,     5'd0);
        chk("rst_bram_dina",      bram_dina,      32'h0);
        chk("rst_cpu_ready",      cpu_req_ready,  1'b1);
        chk("rst_fill_ready",     fill_req_ready, 1'b1);
        rst = 1'b1;
        next_cycle();

        // CPU read of index 5, response one cycle after grant
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_index = 5'd5;
        @(negedge clk);
        chk("rd5_ready", cpu_req_ready, 1'b1);
        chk("rd5_ena",   bram_ena,      1'b1);
        chk("rd5_wea",   bram_wea,      1'b0);
        chk("rd5_addr",  bram_addra,    5'd5);
        next_cycle();
        cpu_req_valid = 1'b0;
        @(negedge clk);
        chk("rd5_rsp_valid",  cpu_rsp_valid,  1'b1);
        chk("rd5_rsp_data",   cpu_rsp_data,   32'hA5A5_A5A5);
        chk("rd5_fill_valid", fill_rsp_valid, 1'b0);
        chk("rd5_fill_data",  fill_rsp_data,  32'h0);
        next_cycle();

        // Both requesting every cycle: CPU wins 4, fill forced on the 5th
        cpu_req_valid  = 1'b1; cpu_req_we  = 1'b1; cpu_req_index  = 5'd20; cpu_req_data  = 32'hC0C0_0020;
        fill_req_valid = 1'b1; fill_req_we = 1'b1; fill_req_index = 5'd21; fill_req_data = 32'hF1F1_0021;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("starve_cpu_ready",  cpu_req_ready,  (k % 5) != 4);
            chk("starve_fill_ready", fill_req_ready, (k % 5) == 4);
            chk("starve_addr",       bram_addra,     ((k % 5) == 4) ? 5'd21 : 5'd20);
            next_cycle();
        end
        idle_inputs();

        // fill_lock burst: 8 fill writes while the CPU keeps requesting
        fill_lock = 1'b1;
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_index = 5'd9;
        fill_req_valid = 1'b1; fill_req_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fill_req_index = 5'(i);
            fill_req_data  = 32'hF000_0000 | 32'(i);
            @(negedge clk);
            chk("lock_cpu_ready",  cpu_req_ready,  1'b0);
            chk("lock_fill_ready", fill_req_ready, 1'b1);
            chk("lock_ena",        bram_ena,       1'b1);
            chk("lock_wea",        bram_wea,       1'b1);
            chk("lock_addr",       bram_addra,     5'(i));
            chk("lock_dina",       bram_dina,      32'hF000_0000 | 32'(i));
            chk("lock_cpu_rsp",    cpu_rsp_valid,  1'b0);
            chk("lock_fill_rsp",   fill_rsp_valid, 1'b0);
            next_cycle();
        end
        // Lock held with no fill request: port idles, CPU still blocked, addr holds
        fill_req_valid = 1'b0;
        @(negedge clk);
        chk("lockidle_cpu_ready", cpu_req_ready, 1'b0);
        chk("lockidle_ena",       bram_ena,      1'b0);
        chk("lockidle_wea",       bram_wea,      1'b0);
        chk("lockidle_addr_hold", bram_addra,    5'd7);
        chk("lockidle_cpu_rsp",   cpu_rsp_valid, 1'b0);
        chk("lock_mem3",          mem[3],        32'hF000_0003);
        chk("lock_mem7",          mem[7],        32'hF000_0007);
        next_cycle();
        idle_inputs();

        // Alternating CPU read 3 / fill read 9
        for (int c = 0; c < 6; c++) begin
            cpu_req_valid  = (c < 4) && ((c % 2) == 0);
            cpu_req_we     = 1'b0;
            cpu_req_index  = 5'd3;
            fill_req_valid = (c < 4) && ((c % 2) == 1);
            fill_req_we    = 1'b0;
            fill_req_index = 5'd9;
            @(negedge clk);
            chk("alt_cpu_rsp_valid",  cpu_rsp_valid,  (c == 1) || (c == 3));
            chk("alt_fill_rsp_valid", fill_rsp_valid, (c == 2) || (c == 4));
            chk("alt_cpu_rsp_data",   cpu_rsp_data,   ((c == 1) || (c == 3)) ? 32'hF000_0003 : 32'h0);
            chk("alt_fill_rsp_data",  fill_rsp_data,  ((c == 2) || (c == 4)) ? 32'h9999_9999 : 32'h0);
            next_cycle();
        end
        idle_inputs();

        // Reset right after a granted CPU read: the response is dropped
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_index = 5'd5;
        next_cycle();
        rst = 1'b0;
        cpu_req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_cpu_rsp",  cpu_rsp_valid,  1'b0);
        chk("midrst_fill_rsp", fill_rsp_valid, 1'b0);
        chk("midrst_ena",      bram_ena,       1'b0);
        chk("midrst_addr",     bram_addra,     5'd0);
        chk("midrst_dina",     bram_dina,      32'h0);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_index = 5'd7; cpu_req_data = 32'hDEAD_BEEF;
        #1;
        chk("midrst_cpu_ready_comb", cpu_req_ready, 1'b1);
        chk("midrst_ena_req",        bram_ena,      1'b0);
        chk("midrst_wea_req",        bram_wea,      1'b0);
        chk("midrst_dina_req",       bram_dina,     32'h0);
        idle_inputs();
        next_cycle();
        @(negedge clk);
        chk("midrst_cpu_rsp_later", cpu_rsp_valid, 1'b0);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("postrst_cpu_rsp", cpu_rsp_valid, 1'b0);
        chk("postrst_mem7",    mem[7],        32'hF000_0007);
        next_cycle();

        // CPU write 12 then immediate read of 12
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_index = 5'd12; cpu_req_data = 32'h3C3C_3C3C;
        @(negedge clk);
        chk("wr12_wea", bram_wea, 1'b1);
        next_cycle();
        cpu_req_we = 1'b0; cpu_req_data = 32'h0;
        @(negedge clk);
        chk("wr12_no_rsp", cpu_rsp_valid, 1'b0);
        chk("rd12_ena",    bram_ena,      1'b1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("rd12_rsp_valid", cpu_rsp_valid, 1'b1);
        chk("rd12_rsp_data",  cpu_rsp_data,  32'h3C3C_3C3C);
        next_cycle();
        @(negedge clk);
        chk("rd12_single_rsp", cpu_rsp_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
